// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single data_mem port, with bounded lock bursts.
// Optional performance counters are enabled by defining DMEM_ARB_PERF_CNT_EN.
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  we0,
    input  logic                  lock0,
    input  logic [DATA_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  gnt0,
    output logic                  rvalid0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic                  lock1,
    input  logic [DATA_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0] mem_wd,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rd,
    output logic                  busy
`ifdef DMEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]           conflict_cnt,
    output logic [15:0]           wait1_max
`endif
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_LIMIT = CW'(MAX_BURST);

    // Handshake: a transfer happens in any cycle where req and gnt are both high; a requester
    // left waiting keeps req and its payload stable, and rvalid answers every transfer one cycle later.

    // busy doubles as "a lock owner exists"; owner_idx names it.
    logic          last_served;
    logic          owner_idx;
    logic [CW-1:0] burst_cnt;

    logic burst_full, hold0, hold1, break0, break1, lock_broken, lock_g;

    always_comb begin
        burst_full  = (burst_cnt == BURST_LIMIT);
        hold0       = busy && !owner_idx && req0;
        hold1       = busy &&  owner_idx && req1;
        break0      = hold0 && burst_full && req1;
        break1      = hold1 && burst_full && req0;
        lock_broken = break0 || break1;

        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (hold0 && !break0) begin
            gnt0 = 1'b1;
        end else if (hold1 && !break1) begin
            gnt1 = 1'b1;
        end else if (break0) begin
            gnt1 = 1'b1;
        end else if (break1) begin
            gnt0 = 1'b1;
        end else if (req0 && req1) begin
            gnt0 = last_served;
            gnt1 = !last_served;
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end

        lock_g = gnt1 ? lock1 : (gnt0 ? lock0 : 1'b0);
    end

    always_comb begin
        mem_we = (gnt0 && we0) || (gnt1 && we1);
        mem_a  = gnt0 ? addr0  : (gnt1 ? addr1  : '0);
        mem_wd = gnt0 ? wdata0 : (gnt1 ? wdata1 : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid0     <= 1'b0;
            rvalid1     <= 1'b0;
            rdata0      <= '0;
            rdata1      <= '0;
            busy        <= 1'b0;
            owner_idx   <= 1'b0;
            burst_cnt   <= '0;
            last_served <= 1'b1;
        end else begin
            rvalid0 <= gnt0;
            rvalid1 <= gnt1;
            if (gnt0 && !we0) rdata0 <= mem_rd;
            if (gnt1 && !we1) rdata1 <= mem_rd;

            if ((gnt0 || gnt1) && lock_g && !lock_broken) begin
                busy      <= 1'b1;
                owner_idx <= gnt1;
                // A fresh owner starts its burst at one; a continuing owner saturates.
                if (busy && (owner_idx == gnt1)) begin
                    if (!burst_full) burst_cnt <= burst_cnt + 1'b1;
                end else begin
                    burst_cnt <= CW'(1);
                end
            end else begin
                busy      <= 1'b0;
                owner_idx <= 1'b0;
                burst_cnt <= '0;
            end

            if (gnt0 || gnt1) last_served <= gnt1;
        end
    end

`ifdef DMEM_ARB_PERF_CNT_EN
    logic [15:0] wait1_run;
    logic [15:0] wait1_next;

    always_comb begin
        wait1_next = (wait1_run == 16'hFFFF) ? wait1_run : wait1_run + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
            wait1_run    <= '0;
            wait1_max    <= '0;
        end else begin
            if (req0 && req1) conflict_cnt <= conflict_cnt + 32'd1;
            if (req1 && !gnt1) begin
                wait1_run <= wait1_next;
                if (wait1_next > wait1_max) wait1_max <= wait1_next;
            end else begin
                wait1_run <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector tables for grants and the memory mux, a scoreboard for read returns.
// Define DMEM_ARB_PERF_CNT_EN to also check the performance counters.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0, we0, lock0, req1, we1, lock1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_we, busy;
    logic [31:0] rdata0, rdata1, mem_a, mem_wd, mem_rd;
`ifdef DMEM_ARB_PERF_CNT_EN
    logic [31:0] conflict_cnt;
    logic [15:0] wait1_max;
`endif

    dmem_arbiter #(.DATA_WIDTH(32), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd),
        .busy(busy)
`ifdef DMEM_ARB_PERF_CNT_EN
        ,
        .conflict_cnt(conflict_cnt), .wait1_max(wait1_max)
`endif
    );

    // Clock / reset
    always #5 clk = ~clk;

    // data_mem stand-in, reloaded from the reference image while reset is held.
    logic [31:0] tb_mem [256];
    logic [31:0] ref_mem[256];
    assign mem_rd = tb_mem[mem_a[7:0]];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= ref_mem[i];
        end else if (mem_we) begin
            tb_mem[mem_a[7:0]] <= mem_wd;
        end
    end

    typedef struct {
        logic        r0, w0, l0;
        logic [31:0] a0, d0;
        logic        r1, w1, l1;
        logic [31:0] a1, d1;
        logic        eg0, eg1, ebusy;
    } vec_t;

    function automatic vec_t mk(input logic r0, input logic w0, input logic l0,
                                input logic [31:0] a0, input logic [31:0] d0,
                                input logic r1, input logic w1, input logic l1,
                                input logic [31:0] a1, input logic [31:0] d1,
                                input logic eg0, input logic eg1, input logic ebusy);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
        v.eg0 = eg0; v.eg1 = eg1; v.ebusy = ebusy;
        return v;
    endfunction

    // Scoreboard
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    logic [31:0] last_rdata0, last_rdata1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_rvalid(input string tag);
        logic [31:0] e;
        check({tag, ".rvalid0"}, {31'd0, rvalid0}, {31'd0, exp_q0.size() != 0});
        check({tag, ".rvalid1"}, {31'd0, rvalid1}, {31'd0, exp_q1.size() != 0});
        if (exp_q0.size() != 0) begin
            e = exp_q0.pop_front();
            check({tag, ".rdata0"}, rdata0, e);
        end
        if (exp_q1.size() != 0) begin
            e = exp_q1.pop_front();
            check({tag, ".rdata1"}, rdata1, e);
        end
    endtask

    // Driver
    task automatic drive_idle();
        req0 = 1'b0; we0 = 1'b0; lock0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; lock1 = 1'b0; addr1 = '0; wdata1 = '0;
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        logic        e_we;
        logic [31:0] e_a, e_wd;
        @(negedge clk);
        req0 = v.r0; we0 = v.w0; lock0 = v.l0; addr0 = v.a0; wdata0 = v.d0;
        req1 = v.r1; we1 = v.w1; lock1 = v.l1; addr1 = v.a1; wdata1 = v.d1;
        #1;
        check_rvalid(tag);
        e_we = (v.eg0 && v.w0) || (v.eg1 && v.w1);
        e_a  = v.eg0 ? v.a0 : (v.eg1 ? v.a1 : 32'd0);
        e_wd = v.eg0 ? v.d0 : (v.eg1 ? v.d1 : 32'd0);
        check({tag, ".gnt0"},   {31'd0, gnt0},   {31'd0, v.eg0});
        check({tag, ".gnt1"},   {31'd0, gnt1},   {31'd0, v.eg1});
        check({tag, ".busy"},   {31'd0, busy},   {31'd0, v.ebusy});
        check({tag, ".mem_we"}, {31'd0, mem_we}, {31'd0, e_we});
        check({tag, ".mem_a"},  mem_a,  e_a);
        check({tag, ".mem_wd"}, mem_wd, e_wd);
        if (v.eg0) begin
            if (v.w0) ref_mem[v.a0[7:0]] = v.d0;
            else      last_rdata0 = ref_mem[v.a0[7:0]];
            exp_q0.push_back(last_rdata0);
        end
        if (v.eg1) begin
            if (v.w1) ref_mem[v.a1[7:0]] = v.d1;
            else      last_rdata1 = ref_mem[v.a1[7:0]];
            exp_q1.push_back(last_rdata1);
        end
    endtask

    vec_t tbl_a[19];
    vec_t tbl_b[7];

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'hA000_0000 + i;
        ref_mem[8'h10] = 32'hDEAD_BEEF;

        //              r0 w0 l0 a0     d0   r1 w1 l1 a1     d1          g0 g1 busy
        tbl_a[0]  = mk(1, 0, 0, 'h10, 0,   0, 0, 0, 0,     0,          1, 0, 0);
        tbl_a[1]  = mk(0, 0, 0, 0,    0,   0, 0, 0, 0,     0,          0, 0, 0);
        tbl_a[2]  = mk(0, 0, 0, 0,    0,   1, 1, 0, 'h20,  'h55,       0, 1, 0);
        tbl_a[3]  = mk(1, 0, 0, 'h20, 0,   0, 0, 0, 0,     0,          1, 0, 0);
        tbl_a[4]  = mk(1, 0, 0, 'h21, 0,   1, 0, 0, 'h22,  0,          0, 1, 0);
        tbl_a[5]  = mk(1, 0, 0, 'h21, 0,   1, 1, 0, 'h23,  'h1234,     1, 0, 0);
        tbl_a[6]  = mk(1, 0, 0, 'h24, 0,   1, 1, 0, 'h23,  'h1234,     0, 1, 0);
        tbl_a[7]  = mk(1, 0, 0, 'h24, 0,   0, 0, 0, 0,     0,          1, 0, 0);
        tbl_a[8]  = mk(1, 0, 0, 'h23, 0,   0, 0, 0, 0,     0,          1, 0, 0);
        tbl_a[9]  = mk(0, 0, 0, 0,    0,   1, 0, 1, 'h30,  0,          0, 1, 0);
        tbl_a[10] = mk(1, 0, 0, 'h40, 0,   1, 0, 1, 'h31,  0,          0, 1, 1);
        tbl_a[11] = mk(1, 0, 0, 'h40, 0,   1, 0, 1, 'h32,  0,          0, 1, 1);
        tbl_a[12] = mk(1, 0, 0, 'h40, 0,   1, 0, 1, 'h33,  0,          0, 1, 1);
        tbl_a[13] = mk(1, 0, 0, 'h40, 0,   1, 0, 1, 'h34,  0,          1, 0, 1);
        tbl_a[14] = mk(0, 0, 0, 0,    0,   1, 0, 1, 'h34,  0,          0, 1, 0);
        tbl_a[15] = mk(1, 0, 0, 'h41, 0,   0, 0, 0, 0,     0,          1, 0, 1);
        tbl_a[16] = mk(0, 0, 0, 0,    0,   0, 0, 0, 0,     0,          0, 0, 0);
        tbl_a[17] = mk(0, 0, 0, 0,    0,   1, 0, 1, 'h35,  0,          0, 1, 0);
        tbl_a[18] = mk(1, 0, 0, 'h42, 0,   1, 0, 1, 'h36,  0,          0, 1, 1);

        tbl_b[0]  = mk(1, 0, 0, 'h50, 0,   1, 0, 0, 'h60,  0,          1, 0, 0);
        tbl_b[1]  = mk(1, 0, 0, 'h51, 0,   1, 0, 0, 'h60,  0,          0, 1, 0);
        tbl_b[2]  = mk(1, 0, 0, 'h51, 0,   1, 0, 0, 'h61,  0,          1, 0, 0);
        tbl_b[3]  = mk(1, 0, 0, 'h52, 0,   1, 0, 0, 'h61,  0,          0, 1, 0);
        tbl_b[4]  = mk(1, 0, 0, 'h52, 0,   1, 0, 0, 'h62,  0,          1, 0, 0);
        tbl_b[5]  = mk(1, 0, 0, 'h53, 0,   1, 0, 0, 'h62,  0,          0, 1, 0);
        tbl_b[6]  = mk(0, 0, 0, 0,    0,   0, 0, 0, 0,     0,          0, 0, 0);

        last_rdata0 = '0;
        last_rdata1 = '0;

        rst = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        #1;
        check("reset.busy",    {31'd0, busy},    32'd0);
        check("reset.rvalid0", {31'd0, rvalid0}, 32'd0);
        check("reset.rvalid1", {31'd0, rvalid1}, 32'd0);
        check("reset.rdata0",  rdata0, 32'd0);
        check("reset.rdata1",  rdata1, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) apply_vec(tbl_a[i], $sformatf("a[%0d]", i));

        // Reset in the middle of requester 1's locked burst, with its read return still in flight.
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        #1;
        check_rvalid("midrst");
        last_rdata0 = '0;
        last_rdata1 = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("postrst.busy",    {31'd0, busy},    32'd0);
        check("postrst.rvalid0", {31'd0, rvalid0}, 32'd0);
        check("postrst.rvalid1", {31'd0, rvalid1}, 32'd0);
        check("postrst.rdata0",  rdata0, 32'd0);
        check("postrst.rdata1",  rdata1, 32'd0);

        for (int i = 0; i < 7; i++) apply_vec(tbl_b[i], $sformatf("b[%0d]", i));
`ifdef DMEM_ARB_PERF_CNT_EN
        check("perf.conflict_cnt", conflict_cnt, 32'd6);
        check("perf.wait1_max",    {16'd0, wait1_max}, 32'd1);
`endif

        // Back-to-back reads from requester 0 must return data every cycle.
        for (int i = 0; i < 16; i++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 63));
            apply_vec(mk(1, 0, 0, a, 0, 0, 0, 0, 0, 0, 1, 0, 0), $sformatf("rnd[%0d]", i));
        end
        apply_vec(tbl_b[6], "flush");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
